// File: rtl/cla_seq_ctrl.sv
// Nibble-serial WIDTH-bit add/subtract sequencer driving a shared 4-bit registered CLA adder.
// Optional signed-overflow output is enabled by defining CLA_SEQ_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start_in, adder inputs held at 0
// ISSUE | slice k operands/carry presented to the adder
// WAIT  | absorbing the remaining adder latency (ADD_LAT-1 cycles)
// CAPT  | adder sum/carry for slice k valid, captured at end of cycle
// DONE  | one-cycle result pulse; start_in accepted here too
module cla_seq_ctrl #(
    parameter int WIDTH   = 16,
    parameter int ADD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_in,
    input  logic             sub_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c0_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] result_out,
    output logic             cout_out,
    output logic [3:0]       add_a_out,
    output logic [3:0]       add_b_out,
    output logic             add_c0_out,
    input  logic [3:0]       add_s_in,
    input  logic             add_c4_in
`ifdef CLA_SEQ_OVF_EN
    ,
    output logic             ovf_out
`endif
);

    localparam int NSLICE = WIDTH / 4;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int WCW    = (ADD_LAT > 2) ? $clog2(ADD_LAT - 1) : 1;
    localparam logic [IW-1:0]  LAST_IDX  = IW'(NSLICE - 1);
    localparam logic [WCW-1:0] WAIT_LOAD = WCW'((ADD_LAT > 1) ? ADD_LAT - 2 : 0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        CAPT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [IW-1:0]    idx;
    logic [WCW-1:0]   wait_cnt;
    logic [WIDTH-1:0] op_a, op_b, acc, acc_nxt, b_eff;
    logic             accept, last_capt;

    assign accept    = start_in && ((state == IDLE) || (state == DONE));
    assign last_capt = (state == CAPT) && (idx == LAST_IDX);
    assign busy_out  = (state == ISSUE) || (state == WAIT) || (state == CAPT);
    assign done_out  = (state == DONE);
    assign b_eff     = sub_in ? ~b_in : b_in;
    // Sums are shifted in from the top so the accumulator is complete after NSLICE captures.
    assign acc_nxt   = (acc >> 4) | (WIDTH'(add_s_in) << (WIDTH - 4));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start_in) state_nxt = ISSUE;
            ISSUE: state_nxt = (ADD_LAT == 1) ? CAPT : WAIT;
            WAIT:  if (wait_cnt == '0) state_nxt = CAPT;
            CAPT:  state_nxt = (idx == LAST_IDX) ? DONE : ISSUE;
            DONE:  state_nxt = start_in ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            wait_cnt   <= '0;
            op_a       <= '0;
            op_b       <= '0;
            acc        <= '0;
            add_a_out  <= '0;
            add_b_out  <= '0;
            add_c0_out <= 1'b0;
        end else begin
            if (state == ISSUE)
                wait_cnt <= WAIT_LOAD;
            else if ((state == WAIT) && (wait_cnt != '0))
                wait_cnt <= wait_cnt - 1'b1;

            if (accept) begin
                idx        <= '0;
                acc        <= '0;
                add_a_out  <= a_in[3:0];
                add_b_out  <= b_eff[3:0];
                add_c0_out <= sub_in ? 1'b1 : c0_in;
                op_a       <= a_in >> 4;
                op_b       <= b_eff >> 4;
            end else if (state == CAPT) begin
                acc <= acc_nxt;
                idx <= idx + 1'b1;
                if (idx == LAST_IDX) begin
                    add_a_out  <= '0;
                    add_b_out  <= '0;
                    add_c0_out <= 1'b0;
                end else begin
                    // The adder's carry-out becomes the carry-in of the next slice.
                    add_a_out  <= op_a[3:0];
                    add_b_out  <= op_b[3:0];
                    add_c0_out <= add_c4_in;
                    op_a       <= op_a >> 4;
                    op_b       <= op_b >> 4;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_out <= '0;
            cout_out   <= 1'b0;
        end else if (last_capt) begin
            result_out <= acc_nxt;
            cout_out   <= add_c4_in;
        end
    end

`ifdef CLA_SEQ_OVF_EN
    // During the last CAPT the adder inputs still hold the MSB slice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_out <= 1'b0;
        else if (last_capt)
            ovf_out <= (add_a_out[3] == add_b_out[3]) && (add_s_in[3] != add_a_out[3]);
    end
`endif

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Scoreboard bench for cla_seq_ctrl (WIDTH=16, ADD_LAT=1) with a registered 4-bit adder model.
module tb_cla_seq_ctrl;

    logic        clk = 1'b0, rst = 1'b0;
    logic        start = 1'b0, sub = 1'b0, c0 = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy, done, cout, add_c0, c4_mdl = 1'b0;
    logic [15:0] result;
    logic [3:0]  add_a, add_b, s_mdl = '0;
`ifdef CLA_SEQ_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] res;
        logic        cout;
        logic        ovf;
        int          due;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    cla_seq_ctrl #(.WIDTH(16), .ADD_LAT(1)) dut (
        .clk(clk), .rst(rst), .start_in(start), .sub_in(sub),
        .a_in(a), .b_in(b), .c0_in(c0),
        .busy_out(busy), .done_out(done), .result_out(result), .cout_out(cout),
        .add_a_out(add_a), .add_b_out(add_b), .add_c0_out(add_c0),
        .add_s_in(s_mdl), .add_c4_in(c4_mdl)
`ifdef CLA_SEQ_OVF_EN
        , .ovf_out(ovf)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        {c4_mdl, s_mdl} <= {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_c0};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = q.pop_front();
                chk("result", 32'(result), 32'(mon_e.res));
                chk("cout", 32'(cout), 32'(mon_e.cout));
                chk("done_cycle", cyc, mon_e.due);
`ifdef CLA_SEQ_OVF_EN
                chk("ovf", 32'(ovf), 32'(mon_e.ovf));
`endif
            end
        end
    end

    // Called at a falling edge; the request is accepted on the following rising edge.
    task automatic start_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc0,
                            input logic tsub, input logic [15:0] eres, input logic ecout,
                            input logic eovf);
        exp_t e;
        a = ta; b = tb; c0 = tc0; sub = tsub; start = 1'b1;
        e.res = eres; e.cout = ecout; e.ovf = eovf; e.due = cyc + 9;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("done_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        #1 rst = 1'b1;
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_cout", 32'(cout), 0);
        chk("rst_add", {add_a, add_b, add_c0}, 0);
        @(negedge clk) rst = 1'b0;

        // Async reset mid-operation
        start_op(16'h5678, 16'h1111, 1'b0, 1'b0, 16'h6789, 1'b0, 1'b0);
        chk("busy_in_op", 32'(busy), 1);
        chk("slice0_a", 32'(add_a), 32'h8);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_busy", 32'(busy), 0);
        chk("async_done", 32'(done), 0);
        chk("async_result", 32'(result), 0);
        chk("async_add", {add_a, add_b, add_c0}, 0);
        q.delete();
        @(negedge clk) rst = 1'b0;

        start_op(16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
        wait_idle();
        start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        wait_idle();
        start_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        wait_idle();
        start_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        wait_idle();
        start_op(16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        wait_idle();
        start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        wait_idle();

        // Ignored mid-op start, then back-to-back start in the DONE cycle
        start_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
        @(negedge clk);
        a = 16'hAAAA; b = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            chk("b2b_done_timeout", 32'(done), 1);
            q.delete();
        end else begin
            start_op(16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        end
        wait_idle();

        // Reset discards an operation in flight
        start_op(16'h1111, 16'h1111, 1'b0, 1'b0, 16'h2222, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_result", 32'(result), 0);
        chk("rst_mid_done", 32'(done), 0);
        q.delete();
        @(negedge clk) rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("discarded_result", 32'(result), 0);
        start_op(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);
        wait_idle();
        chk("post_idle_busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
